trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
// Sequences traps and trap returns for the RV32I pipeline. It accepts illegal-instruction,
// ECALL and MRET events from the EX stage and drives the pipeline flush and stall lines.
// It performs the mepc/mcause/mtval writes one per cycle through the single CSR write port,
// then redirects the PC. It also owns the is_e_cause_eq_ecall flag consumed by the decoder.
// PARAMETERS
// MEPC_ADDR      12'h341  CSR address written with the trapping PC
// MCAUSE_ADDR    12'h342  CSR address written with the cause code
// MTVAL_ADDR     12'h343  CSR address written with the trap value
// CAUSE_ILLEGAL  32'd2    mcause value for an illegal instruction
// CAUSE_ECALL    32'd11   mcause value for ECALL from M-mode
// PORTS
// clk                  in   1   clock, all state updates on the rising edge
// rst                  in   1   asynchronous, active-high reset
// ex_valid_i           in   1   EX stage holds a valid instruction this cycle
// ex_illegal_i         in   1   EX instruction is illegal
// ex_ecall_i           in   1   EX instruction is ECALL
// ex_mret_i            in   1   EX instruction is MRET
// ex_pc_i              in   32  PC of the EX instruction
// ex_ir_i              in   32  raw instruction word of the EX instruction
// mtvec_i              in   32  current mtvec CSR value
// mret_target_i        in   32  return address already computed by EX for MRET
// csr_wr_en_o          out  1   CSR write strobe
// csr_wr_addr_o        out  12  CSR write address
// csr_wr_data_o        out  32  CSR write data
// redirect_o           out  1   PC redirect strobe, 1 cycle
// redirect_pc_o        out  32  PC redirect target
// flush_o              out  1   squash IF/ID/EX contents
// stall_o              out  1   freeze PC and IF/ID; equals busy_o
// busy_o               out  1   state != IDLE
// is_e_cause_eq_ecall  out  1   last taken trap was ECALL (to ID stage)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE. All outputs 0; is_e_cause_eq_ecall=0; latches cleared.
// - States: IDLE, WR_EPC, WR_CAUSE, WR_TVAL, TRAP_JMP, RET_JMP. The FSM is Moore.
//   Outputs depend only on the state and the latched registers, never on the *_i inputs
//   in the same cycle.
// - Acceptance happens only in IDLE with ex_valid_i=1. Priority is illegal > ecall > mret.
// - All events are ignored outside IDLE or when ex_valid_i=0. No queuing.
// - Trap accept (illegal or ecall) at edge N latches the following:
//   - pc  = ex_pc_i
//   - cause = CAUSE_ILLEGAL or CAUSE_ECALL
//   - tval = ex_ir_i for illegal, 0 for ecall
//   - vec = {mtvec_i[31:2],2'b00}
//   The FSM moves to WR_EPC.
// - WR_EPC: wr_en=1, addr=MEPC_ADDR, data=pc. Next state WR_CAUSE.
// - WR_CAUSE: wr_en=1, addr=MCAUSE_ADDR, data=cause. Next state WR_TVAL.
// - WR_TVAL: wr_en=1, addr=MTVAL_ADDR, data=tval. Next state TRAP_JMP.
// - TRAP_JMP: redirect_o=1, redirect_pc_o=vec. The ECALL flag is updated here:
//   is_e_cause_eq_ecall <= (cause==CAUSE_ECALL). Next state IDLE.
// - MRET accept latches tgt=mret_target_i and moves to RET_JMP.
//   RET_JMP: redirect_o=1, redirect_pc_o=tgt, no CSR write, flag unchanged. Next state IDLE.
// - flush_o=1 and stall_o=busy_o=1 in every non-IDLE state; all are 0 in IDLE.
// - csr_wr_addr_o/csr_wr_data_o are 0 whenever csr_wr_en_o=0.
//   redirect_pc_o is 0 whenever redirect_o=0.
// - Latency: a trap is 4 busy cycles with the redirect in the 4th. An MRET is 1 busy cycle.
//   A new event can be accepted in the cycle after TRAP_JMP/RET_JMP.
// - Simultaneous illegal+ecall+mret: only the illegal trap is taken.
// - mtvec_i changes after acceptance have no effect on the current trap.
// TESTING
// - Illegal trap: illegal=1, pc=0x100, ir=0xFFFFFFFF, mtvec=0x203.
//   Expect writes 341<-0x100, 342<-2, 343<-0xFFFFFFFF, then redirect to 0x200 in cycle 4,
//   with flag=0.
// - ECALL then MRET: pc=0x80 gives writes 341<-0x80, 342<-11, 343<-0, then flag=1.
//   MRET with target=0x84 gives a 1-cycle redirect to 0x84, flag still 1, no CSR write.
// - Priority/busy: illegal+ecall together take the illegal trap (cause 2).
//   An ECALL pulsed during WR_CAUSE is dropped; exactly 3 CSR writes occur.
// - ex_valid_i=0 with illegal=1: nothing happens; busy_o stays 0, no writes.
// - Assert rst during WR_CAUSE: all outputs 0 immediately, state IDLE.
//   No WR_TVAL write and no redirect follow.
// - Back-to-back: an MRET presented in the cycle after TRAP_JMP is accepted.
//   Its redirect follows 1 cycle later.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: writes mepc, mcause and mtval through one CSR port, then redirects the PC.
// Latency: a trap is 4 busy cycles (3 CSR writes, then a redirect); MRET is 1 busy cycle (redirect).
// Backpressure: none. Events arriving while busy or without ex_valid_i are dropped; stall_o freezes the front end.
module trap_ctrl #(
    parameter logic [11:0] MEPC_ADDR     = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR   = 12'h342,
    parameter logic [11:0] MTVAL_ADDR    = 12'h343,
    parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
    parameter logic [31:0] CAUSE_ECALL   = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        ex_illegal_i,
    input  logic        ex_ecall_i,
    input  logic        ex_mret_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_ir_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mret_target_i,
    output logic        csr_wr_en_o,
    output logic [11:0] csr_wr_addr_o,
    output logic [31:0] csr_wr_data_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        is_e_cause_eq_ecall
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_EPC   = 3'd1,
        S_WR_CAUSE = 3'd2,
        S_WR_TVAL  = 3'd3,
        S_TRAP_JMP = 3'd4,
        S_RET_JMP  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Values captured at acceptance so later input changes (e.g. mtvec_i) cannot disturb a trap in flight
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic [31:0] r_tval;
    logic [31:0] r_vec;
    logic [31:0] r_tgt;
    logic        r_ecall_flag;

    logic        w_accept;
    logic        w_take_trap;
    logic        w_take_mret;

    // Events are only considered in IDLE; illegal beats ecall beats mret
    assign w_accept    = (r_state == S_IDLE) && ex_valid_i;
    assign w_take_trap = w_accept && (ex_illegal_i || ex_ecall_i);
    assign w_take_mret = w_accept && !ex_illegal_i && !ex_ecall_i && ex_mret_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: the write/jump states advance unconditionally
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_trap) begin
                    w_next_state = S_WR_EPC;
                end else if (w_take_mret) begin
                    w_next_state = S_RET_JMP;
                end
            end
            S_WR_EPC:   w_next_state = S_WR_CAUSE;
            S_WR_CAUSE: w_next_state = S_WR_TVAL;
            S_WR_TVAL:  w_next_state = S_TRAP_JMP;
            S_TRAP_JMP: w_next_state = S_IDLE;
            S_RET_JMP:  w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Capture trap context on trap acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_cause <= '0;
            r_tval  <= '0;
            r_vec   <= '0;
        end else if (w_take_trap) begin
            r_pc    <= ex_pc_i;
            r_cause <= ex_illegal_i ? CAUSE_ILLEGAL : CAUSE_ECALL;
            r_tval  <= ex_illegal_i ? ex_ir_i : 32'd0;
            r_vec   <= {mtvec_i[31:2], 2'b00};
        end
    end

    // Capture the MRET return address on MRET acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt <= '0;
        end else if (w_take_mret) begin
            r_tgt <= mret_target_i;
        end
    end

    // ECALL flag for the decoder: refreshed only when a trap actually redirects, MRET leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ecall_flag <= 1'b0;
        end else if (r_state == S_TRAP_JMP) begin
            r_ecall_flag <= (r_cause == CAUSE_ECALL);
        end
    end

    // Moore outputs: decoded from state and captured registers only; address/data/pc zeroed when not strobed
    always_comb begin
        csr_wr_en_o   = 1'b0;
        csr_wr_addr_o = '0;
        csr_wr_data_o = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        busy_o        = (r_state != S_IDLE);
        case (r_state)
            S_WR_EPC: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = MEPC_ADDR;
                csr_wr_data_o = r_pc;
            end
            S_WR_CAUSE: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = MCAUSE_ADDR;
                csr_wr_data_o = r_cause;
            end
            S_WR_TVAL: begin
                csr_wr_en_o   = 1'b1;
                csr_wr_addr_o = MTVAL_ADDR;
                csr_wr_data_o = r_tval;
            end
            S_TRAP_JMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = r_vec;
            end
            S_RET_JMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = r_tgt;
            end
            default: begin
                csr_wr_en_o = 1'b0;
            end
        endcase
    end

    assign flush_o             = busy_o;
    assign stall_o             = busy_o;
    assign is_e_cause_eq_ecall = r_ecall_flag;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: illegal trap, ECALL+MRET back-to-back, reset mid-trap, priority, invalid events.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
// Expected values are hand-derived constants.
module tb_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_illegal_i;
    logic        ex_ecall_i;
    logic        ex_mret_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_ir_i;
    logic [31:0] mtvec_i;
    logic [31:0] mret_target_i;
    logic        csr_wr_en_o;
    logic [11:0] csr_wr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        stall_o;
    logic        busy_o;
    logic        is_e_cause_eq_ecall;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_base;
    int rd_base;

    trap_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_valid_i          (ex_valid_i),
        .ex_illegal_i        (ex_illegal_i),
        .ex_ecall_i          (ex_ecall_i),
        .ex_mret_i           (ex_mret_i),
        .ex_pc_i             (ex_pc_i),
        .ex_ir_i             (ex_ir_i),
        .mtvec_i             (mtvec_i),
        .mret_target_i       (mret_target_i),
        .csr_wr_en_o         (csr_wr_en_o),
        .csr_wr_addr_o       (csr_wr_addr_o),
        .csr_wr_data_o       (csr_wr_data_o),
        .redirect_o          (redirect_o),
        .redirect_pc_o       (redirect_pc_o),
        .flush_o             (flush_o),
        .stall_o             (stall_o),
        .busy_o              (busy_o),
        .is_e_cause_eq_ecall (is_e_cause_eq_ecall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        if (csr_wr_en_o) wr_cnt++;
        if (redirect_o)  rd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [11:0] addr,
                              input logic [31:0] data, input logic rd, input logic [31:0] rpc,
                              input logic bz, input logic flag);
        chk({tag, ".wr_en"},   {31'd0, csr_wr_en_o},         {31'd0, we});
        chk({tag, ".wr_addr"}, {20'd0, csr_wr_addr_o},       {20'd0, addr});
        chk({tag, ".wr_data"}, csr_wr_data_o,                data);
        chk({tag, ".redir"},   {31'd0, redirect_o},          {31'd0, rd});
        chk({tag, ".redir_pc"}, redirect_pc_o,               rpc);
        chk({tag, ".busy"},    {31'd0, busy_o},              {31'd0, bz});
        chk({tag, ".stall"},   {31'd0, stall_o},             {31'd0, bz});
        chk({tag, ".flush"},   {31'd0, flush_o},             {31'd0, bz});
        chk({tag, ".flag"},    {31'd0, is_e_cause_eq_ecall}, {31'd0, flag});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i    = 1'b0;
        ex_illegal_i  = 1'b0;
        ex_ecall_i    = 1'b0;
        ex_mret_i     = 1'b0;
        ex_pc_i       = 32'h0;
        ex_ir_i       = 32'h0;
        mret_target_i = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        mtvec_i = 32'h0;
        idle_inputs();
        #1;
        expect_out("reset", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        expect_out("idle0", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Illegal trap; mtvec changes after acceptance must not matter
        ex_valid_i = 1'b1; ex_illegal_i = 1'b1;
        ex_pc_i = 32'h100; ex_ir_i = 32'hFFFF_FFFF; mtvec_i = 32'h203;
        step();
        idle_inputs(); mtvec_i = 32'hFFF0_0000;
        expect_out("ill.epc",   1'b1, 12'h341, 32'h100,       1'b0, 32'h0,   1'b1, 1'b0);
        step();
        expect_out("ill.cause", 1'b1, 12'h342, 32'h2,         1'b0, 32'h0,   1'b1, 1'b0);
        step();
        expect_out("ill.tval",  1'b1, 12'h343, 32'hFFFF_FFFF, 1'b0, 32'h0,   1'b1, 1'b0);
        step();
        expect_out("ill.jmp",   1'b0, 12'h0,   32'h0,         1'b1, 32'h200, 1'b1, 1'b0);
        // MRET offered while still in TRAP_JMP must be dropped
        ex_valid_i = 1'b1; ex_mret_i = 1'b1; mret_target_i = 32'h9999;
        step();
        idle_inputs();
        expect_out("ill.done",  1'b0, 12'h0,   32'h0,         1'b0, 32'h0,   1'b0, 1'b0);
        step();
        expect_out("ill.nomret", 1'b0, 12'h0,  32'h0,         1'b0, 32'h0,   1'b0, 1'b0);

        // ECALL, then MRET in the first IDLE cycle after TRAP_JMP
        ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 32'h80;
        ex_ir_i = 32'h0000_0073; mtvec_i = 32'h1001;
        step();
        idle_inputs();
        expect_out("ecall.epc",   1'b1, 12'h341, 32'h80, 1'b0, 32'h0,    1'b1, 1'b0);
        step();
        expect_out("ecall.cause", 1'b1, 12'h342, 32'd11, 1'b0, 32'h0,    1'b1, 1'b0);
        step();
        expect_out("ecall.tval",  1'b1, 12'h343, 32'h0,  1'b0, 32'h0,    1'b1, 1'b0);
        step();
        expect_out("ecall.jmp",   1'b0, 12'h0,   32'h0,  1'b1, 32'h1000, 1'b1, 1'b0);
        step();
        expect_out("ecall.done",  1'b0, 12'h0,   32'h0,  1'b0, 32'h0,    1'b0, 1'b1);
        wr_base = wr_cnt;
        ex_valid_i = 1'b1; ex_mret_i = 1'b1; mret_target_i = 32'h84;
        step();
        idle_inputs();
        expect_out("mret.jmp",    1'b0, 12'h0,   32'h0,  1'b1, 32'h84,   1'b1, 1'b1);
        step();
        expect_out("mret.done",   1'b0, 12'h0,   32'h0,  1'b0, 32'h0,    1'b0, 1'b1);
        chk("mret.no_csr_write", wr_cnt - wr_base, 0);

        // Reset asserted during WR_CAUSE clears everything at once, including the flag
        ex_valid_i = 1'b1; ex_illegal_i = 1'b1; ex_pc_i = 32'h500; ex_ir_i = 32'hDEAD;
        mtvec_i = 32'h700;
        step();
        idle_inputs();
        step();
        expect_out("rst.cause", 1'b1, 12'h342, 32'h2, 1'b0, 32'h0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        expect_out("rst.async", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        @(negedge clk);
        rst = 1'b0;
        wr_base = wr_cnt; rd_base = rd_cnt;
        step(); step(); step();
        expect_out("rst.after", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst.no_writes",    wr_cnt - wr_base, 0);
        chk("rst.no_redirects", rd_cnt - rd_base, 0);

        // Priority: illegal+ecall+mret takes the illegal trap; ECALL pulsed in WR_CAUSE is dropped
        wr_base = wr_cnt; rd_base = rd_cnt;
        ex_valid_i = 1'b1; ex_illegal_i = 1'b1; ex_ecall_i = 1'b1; ex_mret_i = 1'b1;
        ex_pc_i = 32'h300; ex_ir_i = 32'h1234_5678; mtvec_i = 32'h402; mret_target_i = 32'h55;
        step();
        idle_inputs();
        expect_out("pri.epc",   1'b1, 12'h341, 32'h300,       1'b0, 32'h0,   1'b1, 1'b0);
        step();
        ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 32'h999;
        expect_out("pri.cause", 1'b1, 12'h342, 32'h2,         1'b0, 32'h0,   1'b1, 1'b0);
        step();
        idle_inputs();
        expect_out("pri.tval",  1'b1, 12'h343, 32'h1234_5678, 1'b0, 32'h0,   1'b1, 1'b0);
        step();
        expect_out("pri.jmp",   1'b0, 12'h0,   32'h0,         1'b1, 32'h400, 1'b1, 1'b0);
        step();
        expect_out("pri.done",  1'b0, 12'h0,   32'h0,         1'b0, 32'h0,   1'b0, 1'b0);
        step();
        chk("pri.writes",    wr_cnt - wr_base, 3);
        chk("pri.redirects", rd_cnt - rd_base, 1);

        // Events without ex_valid_i are ignored
        wr_base = wr_cnt;
        ex_illegal_i = 1'b1; ex_ecall_i = 1'b1; ex_mret_i = 1'b1; ex_pc_i = 32'h44;
        step();
        expect_out("noval.1", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        expect_out("noval.2", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle_inputs();
        step();
        chk("noval.writes", wr_cnt - wr_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
